// File: rtl/seq_chunk_alu.sv
// seq_chunk_alu: multi-cycle ALU that computes a WIDTH-bit add/sub/logic result
// CHUNK bits per clock, LSB chunk first, with a start/busy/done handshake.
module seq_chunk_alu #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SUM_W = CHUNK + 1;
    localparam int unsigned CAT_W = WIDTH + CHUNK;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic               accept;
    logic               last;
    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic [CHUNK-1:0]   b_x;
    logic [SUM_W-1:0]   sum;
    logic [CHUNK-1:0]   res_chunk;
    logic               carry_out;
    logic               c_msb_in;
    logic               arith;
    logic [CAT_W-1:0]   acc_cat;
    logic [WIDTH-1:0]   acc_next;

    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last   = (idx_q == IDX_W'(N - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last)  state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the next state so they are registered
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (state_d == S_RUN)  busy_d = 1'b1;
        if (state_d == S_DONE) done_d = 1'b1;
    end

    // One chunk of the selected operation; operands shift right so chunk i is always at the bottom
    always_comb begin
        a_chunk   = a_q[CHUNK-1:0];
        b_chunk   = b_q[CHUNK-1:0];
        b_x       = (op_q == OP_SUB) ? ~b_chunk : b_chunk;
        sum       = {1'b0, a_chunk} + {1'b0, b_x} + SUM_W'(carry_q);
        c_msb_in  = sum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_x[CHUNK-1];
        res_chunk = '0;
        carry_out = 1'b0;
        arith     = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                res_chunk = sum[CHUNK-1:0];
                carry_out = sum[CHUNK];
                arith     = 1'b1;
            end
            OP_AND:  res_chunk = a_chunk & b_chunk;
            OP_OR:   res_chunk = a_chunk | b_chunk;
            OP_XOR:  res_chunk = a_chunk ^ b_chunk;
            default: res_chunk = '0;
        endcase
        acc_cat  = {res_chunk, acc_q};
        acc_next = acc_cat[CAT_W-1:CHUNK];
    end

    // Datapath next-state: operand latch on accept, chunk step in RUN, result load on the last chunk
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        if (state_q == S_RUN) begin
            a_d     = a_q >> CHUNK;
            b_d     = b_q >> CHUNK;
            acc_d   = acc_next;
            carry_d = carry_out;
            idx_d   = idx_q + IDX_W'(1);
            if (last) begin
                result_d = acc_next;
                cout_d   = arith & carry_out;
                ovf_d    = arith & (c_msb_in ^ carry_out);
                zero_d   = (acc_next == '0);
            end
        end
        if (accept) begin
            a_d     = a;
            b_d     = b;
            op_d    = op;
            idx_d   = '0;
            carry_d = (op == OP_SUB);
            acc_d   = '0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_seq_chunk_alu.sv
// Bench for seq_chunk_alu: 8/4 instance driven from a vector table with a
// scoreboard, plus 16/4 and 8/8 instances for the ADD/SUB width variants.
module tb_seq_chunk_alu;

    localparam bit [2:0] OP_ADD = 3'b000;
    localparam bit [2:0] OP_SUB = 3'b001;
    localparam bit [2:0] OP_AND = 3'b010;
    localparam bit [2:0] OP_OR  = 3'b011;
    localparam bit [2:0] OP_XOR = 3'b100;
    localparam int N8 = 2;

    logic clk = 1'b0;
    logic rst_n;

    logic        start, busy, done, cout, ovf, zero;
    logic [2:0]  op;
    logic [7:0]  a, b, result;

    logic        start16, busy16, done16, cout16, ovf16, zero16;
    logic [2:0]  op16;
    logic [15:0] a16, b16, result16;

    logic        start8, busy8, done8, cout8, ovf8, zero8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, result8;

    seq_chunk_alu #(.WIDTH(8), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf), .zero(zero)
    );

    seq_chunk_alu #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .op(op16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(result16), .cout(cout16), .ovf(ovf16), .zero(zero16)
    );

    seq_chunk_alu #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       cout;
        logic       ovf;
        logic       zero;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic       cout;
        logic       ovf;
        logic       zero;
        int         exp_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[11];

    int n_checks = 0;
    int n_pass   = 0;
    int n_issued = 0;
    int n_done   = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard consumer: every done pulse of the 8/4 instance pops one expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            chk("done_single_cycle", 32'(prev_done), 32'd0);
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: done=1 at cycle %0d with no pending op, expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("result",   32'(result), 32'(mon_e.res));
                chk("cout",     32'(cout),   32'(mon_e.cout));
                chk("ovf",      32'(ovf),    32'(mon_e.ovf));
                chk("zero",     32'(zero),   32'(mon_e.zero));
                chk("busy_in_done", 32'(busy), 32'd0);
                chk("latency_cycle", 32'(cyc), 32'(mon_e.exp_cyc));
            end
        end
        prev_done <= done;
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"},   32'(busy),   32'd0);
        chk({tag, "_done"},   32'(done),   32'd0);
        chk({tag, "_result"}, 32'(result), 32'd0);
        chk({tag, "_cout"},   32'(cout),   32'd0);
        chk({tag, "_ovf"},    32'(ovf),    32'd0);
        chk({tag, "_zero"},   32'(zero),   32'd1);
    endtask

    // Drive one op on the 8/4 instance; keep start high for 'hold' extra cycles with junk operands
    task automatic issue(input logic [2:0] o, input logic [7:0] xa, input logic [7:0] xb,
                         input logic [7:0] er, input logic ec, input logic eo, input logic ez,
                         input int hold, input bit expect_done);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = xa;
        b     = xb;
        if (expect_done) begin
            e.res     = er;
            e.cout    = ec;
            e.ovf     = eo;
            e.zero    = ez;
            e.exp_cyc = cyc + 1 + N8;
            sb.push_back(e);
            n_issued++;
        end
        @(posedge clk);
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int h = 0; h < hold; h++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = 3'($urandom_range(0, 7));
            @(negedge clk);
        end
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        op    = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL %s_timeout: %0d ops pending after %0d cycles, expected 0", tag, sb.size(), k);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Single op on the 16/4 (wide=1) or 8/8 (wide=0) instance with direct latency and value checks
    task automatic run_alt(input bit wide, input logic [2:0] o, input logic [15:0] xa,
                           input logic [15:0] xb, input logic [15:0] er,
                           input logic ec, input logic eo, input logic ez);
        int t;
        int k;
        int n_exp;
        logic d;
        n_exp = wide ? 4 : 1;
        @(negedge clk);
        if (wide) begin
            start16 = 1'b1; op16 = o; a16 = xa; b16 = xb;
        end else begin
            start8 = 1'b1; op8 = o; a8 = xa[7:0]; b8 = xb[7:0];
        end
        t = cyc;
        @(negedge clk);
        start16 = 1'b0;
        start8  = 1'b0;
        a16 = 16'($urandom);
        b16 = 16'($urandom);
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        k = 0;
        d = wide ? done16 : done8;
        while (!d && k < 20) begin
            @(negedge clk);
            k++;
            d = wide ? done16 : done8;
        end
        if (!d) begin
            n_checks++;
            $display("FAIL alt_timeout: no done within %0d cycles (wide=%0d), expected done", k, wide);
        end else begin
            chk(wide ? "w16_latency" : "w8_latency", 32'(cyc - t - 1), 32'(n_exp));
            chk(wide ? "w16_result" : "w8_result",
                wide ? 32'(result16) : 32'(result8), wide ? 32'(er) : 32'(er[7:0]));
            chk(wide ? "w16_cout" : "w8_cout", wide ? 32'(cout16) : 32'(cout8), 32'(ec));
            chk(wide ? "w16_ovf" : "w8_ovf", wide ? 32'(ovf16) : 32'(ovf8), 32'(eo));
            chk(wide ? "w16_zero" : "w8_zero", wide ? 32'(zero16) : 32'(zero8), 32'(ez));
            @(negedge clk);
            chk(wide ? "w16_done_pulse" : "w8_done_pulse", wide ? 32'(done16) : 32'(done8), 32'd0);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        int first_done;
        exp_t e;

        vecs[0]  = '{OP_ADD,  8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{OP_ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{OP_ADD,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{OP_SUB,  8'h05, 8'h0A, 8'hFB, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{OP_SUB,  8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{OP_XOR,  8'h55, 8'hAA, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{OP_AND,  8'h0F, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{3'b111,  8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{OP_OR,   8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{OP_SUB,  8'h33, 8'h33, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{3'b101,  8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;   op = 3'd0;   a = 8'd0;   b = 8'd0;
        start16 = 1'b0; op16 = 3'd0; a16 = 16'd0; b16 = 16'd0;
        start8 = 1'b0;  op8 = 3'd0;  a8 = 8'd0;  b8 = 8'd0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                  vecs[i].cout, vecs[i].ovf, vecs[i].zero, 0, 1'b1);
            wait_idle("vec");
        end

        // start held high through RUN must not queue a second operation
        issue(OP_ADD, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0, N8, 1'b1);
        wait_idle("busy_start");

        // start in DONE chains the next op with no idle cycle
        issue(OP_ADD, 8'h40, 8'h01, 8'h41, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL b2b_first_done: no done within %0d cycles, expected done", k);
        end
        first_done = cyc;
        start = 1'b1; op = OP_ADD; a = 8'h10; b = 8'h20;
        e.res = 8'h30; e.cout = 1'b0; e.ovf = 1'b0; e.zero = 1'b0;
        e.exp_cyc = first_done + 3;
        sb.push_back(e);
        n_issued++;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        wait_idle("b2b");

        // asynchronous reset in the middle of RUN aborts the op
        issue(OP_ADD, 8'h11, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(OP_ADD, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        wait_idle("post_rst");

        run_alt(1'b1, OP_ADD, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0);
        run_alt(1'b1, OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_alt(1'b1, OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_alt(1'b1, OP_SUB, 16'h0005, 16'h000A, 16'hFFFB, 1'b0, 1'b0, 1'b0);
        run_alt(1'b0, OP_ADD, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0);
        run_alt(1'b0, OP_ADD, 16'h00FF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_alt(1'b0, OP_ADD, 16'h007F, 16'h0001, 16'h0080, 1'b0, 1'b1, 1'b0);
        run_alt(1'b0, OP_SUB, 16'h0080, 16'h0001, 16'h007F, 1'b1, 1'b1, 1'b0);

        chk("done_count", 32'(n_done), 32'(n_issued));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
